board_supervisor: RTL and testbench
===================================

Name: board_supervisor

Overview:
Parametrised board-level supervisor that sits between the board pins, the host SPI/GPIO bridge and the compute core. It replaces the fixed counter reset generator, the constant LED driver and the hard-wired GPIO loopback with a single block. It provides:
- a lock-aware staged core reset sequencer;
- debounced pushbuttons;
- per-channel selectable GPIO readback;
- a sticky lock-loss flag;
- heartbeat and status LEDs.

Parameters:
NUM_GPIO, 8, number of 32-bit-style host GPIO channels
GPIO_W, 32, width of each GPIO channel (must be >= 3+NUM_SW)
CORE_CH, 1, host channel forwarded to the core
RST_HOLD, 32'h0000ffff, cycles core_reset is held after lock is seen (>=1)
SYNC_STAGES, 2, synchroniser depth for locked and switch_n (>=2)
NUM_SW, 3, number of pushbuttons
DEB_CYC, 16'd50000, consecutive stable cycles to accept a switch change (>=1)
HB_W, 23, heartbeat counter width
NUM_LED, 3, LED count (>=3)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
locked  in  1  clock-source lock, asynchronous
switch_n  in  NUM_SW  pushbuttons, active-low, asynchronous
host_gpio_out  in  NUM_GPIO*GPIO_W  host-written channels; channel k at [k*GPIO_W +: GPIO_W]
host_gpio_in  out  NUM_GPIO*GPIO_W  host readback channels, same packing
chan_mode  in  2*NUM_GPIO  readback mode per channel; channel k at [2k +: 2]
core_gpio_out  in  GPIO_W  core result word
core_gpio_in  out  GPIO_W  registered copy of host channel CORE_CH
core_reset  out  1  active-high reset to core, synchronous to clk
led  out  NUM_LED  LED drive, 1 = on

Behaviour:
- Reset (synchronous, active-high), applies mid-operation as well:
  - state=HOLD; all counters, synchronisers, debounced switches and lock_err cleared.
  - Every output 0 except core_reset=1.
- Synchronisers:
  - locked and ~switch_n each pass through SYNC_STAGES flops, giving locked_s and sw_s.
- Sequencer (FSM HOLD=0, COUNT=1, RUN=2):
  - HOLD: cnt=0. locked_s=1 -> COUNT.
  - COUNT: cnt increments each cycle. locked_s=0 -> HOLD with cnt cleared. cnt==RST_HOLD-1 -> RUN.
  - RUN: locked_s=0 -> HOLD and set lock_err.
  - core_reset = (state!=RUN), decoded from the state register only; no combinational input path.
- Debounce, per switch:
  - Per-switch counter resets whenever sw_s differs from deb.
  - deb updates to sw_s once the counter reaches DEB_CYC-1.
  - A bounce restarts the count.
- lock_err:
  - Sticky; cleared in any cycle where deb[0]=1.
  - Set wins over clear in the same cycle.
- Free-running cycle counter: GPIO_W bits, wraps to 0, cleared only by reset.
- core_gpio_in: 1-cycle registered copy of host channel CORE_CH.
- host_gpio_in channel k, registered with 1-cycle latency, selected by chan_mode[2k+:2]:
  - 0: host_gpio_out channel k (loopback).
  - 1: core_gpio_out, forced to 0 while core_reset=1.
  - 2: status word: [1:0]=state, [2]=lock_err, [3+:NUM_SW]=deb, remaining bits 0.
  - 3: cycle counter value.
  - A mode change takes effect on the next registered word; no glitch beyond that.
- LEDs, all registered:
  - led[0] = MSB of an HB_W-bit heartbeat counter that runs only in RUN and is held at 0 otherwise.
  - led[1] = ~core_reset.
  - led[2] = lock_err.
  - led[i] for i>=3 = deb[i-3] when i-3 < NUM_SW, else 0.

Test Plan:
1. RST_HOLD=16, SYNC_STAGES=2, locked=1 throughout -> release reset at edge e0 -> core_reset=1 through e0+17, 0 from edge e0+18. led[1] rises one cycle later.
2. Same setup, drop locked for 4 cycles when cnt=8 -> state returns to HOLD. After relock, core_reset again stays high the full 16 COUNT cycles. lock_err stays 0.
3. In RUN, drop locked -> core_reset=1 within 3 cycles; lock_err=1; led[2]=1; a mode-2 channel reads bit2=1. Hold switch_n[0]=0 for DEB_CYC+SYNC_STAGES+1 cycles -> lock_err=0.
4. chan_mode ch3=0 with host ch3=32'hA5A5_0001 -> host_gpio_in ch3=32'hA5A5_0001 one cycle later. Set ch3 mode=1 with core_gpio_out=32'h0000_1234: during core_reset reads 0; in RUN reads 32'h0000_1234.
5. DEB_CYC=8, toggle switch_n[1] every 2 cycles for 20 cycles -> deb[1] unchanged. Hold low 8+ cycles -> deb[1]=1; led[4]=1 when NUM_LED>=5.
6. HB_W=4, in RUN -> led[0] toggles every 8 cycles. Force HOLD via locked=0 -> led[0]=0 and heartbeat counter cleared.

Source files
------------

// File: rtl/board_supervisor.sv
// board_supervisor: board-level glue between pins, the host GPIO bridge and the compute core.
//   - Lock-aware staged core reset: the core leaves reset only after the clock source has
//     stayed locked for RST_HOLD consecutive cycles; losing lock in RUN sets a sticky lock_err.
//   - Debounced active-low pushbuttons; deb[0] doubles as the lock_err acknowledge.
//   - Per-channel host readback: loopback, core word, status word or free-running cycle count.
//   - Heartbeat, run, error and switch LEDs.
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   locked           clock-source lock (asynchronous)
//   switch_n         pushbuttons, active-low (asynchronous)
//   host_gpio_out    host-written channels, channel k at [k*GPIO_W +: GPIO_W]
//   host_gpio_in     registered host readback channels, same packing
//   chan_mode        readback mode per channel, channel k at [2k +: 2]
//   core_gpio_out    core result word
//   core_gpio_in     registered copy of host channel CORE_CH
//   core_reset       active-high core reset, decoded from the sequencer state register
//   led              LED drive, 1 = on
module board_supervisor #(
  parameter int unsigned NUM_GPIO    = 8,
  parameter int unsigned GPIO_W      = 32,
  parameter int unsigned CORE_CH     = 1,
  parameter logic [31:0] RST_HOLD    = 32'h0000ffff,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_SW      = 3,
  parameter logic [15:0] DEB_CYC     = 16'd50000,
  parameter int unsigned HB_W        = 23,
  parameter int unsigned NUM_LED     = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       locked,
  input  logic [NUM_SW-1:0]          switch_n,
  input  logic [NUM_GPIO*GPIO_W-1:0] host_gpio_out,
  output logic [NUM_GPIO*GPIO_W-1:0] host_gpio_in,
  input  logic [2*NUM_GPIO-1:0]      chan_mode,
  input  logic [GPIO_W-1:0]          core_gpio_out,
  output logic [GPIO_W-1:0]          core_gpio_in,
  output logic                       core_reset,
  output logic [NUM_LED-1:0]         led
);

  typedef enum logic [1:0] {
    StHold  = 2'd0,
    StCount = 2'd1,
    StRun   = 2'd2
  } state_e;

  // Synchronisers
  logic [SYNC_STAGES-1:0]             lock_sync_q, lock_sync_d;
  logic [SYNC_STAGES-1:0][NUM_SW-1:0] sw_sync_q, sw_sync_d;
  logic                               locked_s;
  logic [NUM_SW-1:0]                  sw_s;

  // Sequencer
  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        lock_lost;

  // Debounce
  logic [NUM_SW-1:0]        deb_q, deb_d;
  logic [NUM_SW-1:0][15:0]  deb_cnt_q, deb_cnt_d;

  // Misc state
  logic                       lock_err_q, lock_err_d;
  logic [GPIO_W-1:0]          cyc_q, cyc_d;
  logic [HB_W-1:0]            hb_q, hb_d;
  logic [GPIO_W-1:0]          core_in_q, core_in_d;
  logic [NUM_GPIO*GPIO_W-1:0] host_in_q, host_in_d;
  logic [NUM_LED-1:0]         led_q, led_d;

  logic [GPIO_W-1:0] status_word;
  logic [GPIO_W-1:0] core_word;

  assign lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], locked};
  assign sw_sync_d   = {sw_sync_q[SYNC_STAGES-2:0], ~switch_n};
  assign locked_s    = lock_sync_q[SYNC_STAGES-1];
  assign sw_s        = sw_sync_q[SYNC_STAGES-1];

  // Decoded from the state register only so core_reset has no path from any input.
  assign core_reset = (state_q != StRun);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lock_lost = 1'b0;
    unique case (state_q)
      StHold: begin
        cnt_d = '0;
        if (locked_s) state_d = StCount;
      end
      StCount: begin
        if (!locked_s) begin
          state_d = StHold;
          cnt_d   = '0;
        end else if (cnt_q == RST_HOLD - 32'd1) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StRun: begin
        if (!locked_s) begin
          state_d   = StHold;
          lock_lost = 1'b1;
        end
      end
      default: begin
        state_d = StHold;
        cnt_d   = '0;
      end
    endcase
  end

  // A switch change is accepted only after DEB_CYC consecutive differing samples;
  // any sample agreeing with the accepted value restarts the count.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    for (int unsigned i = 0; i < NUM_SW; i++) begin
      if (sw_s[i] == deb_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_CYC - 16'd1) begin
        deb_d[i]     = sw_s[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 16'd1;
      end
    end
  end

  // Setting wins over the deb[0] acknowledge.
  always_comb begin
    lock_err_d = lock_err_q;
    if (lock_lost) begin
      lock_err_d = 1'b1;
    end else if (deb_q[0]) begin
      lock_err_d = 1'b0;
    end
  end

  assign cyc_d     = cyc_q + GPIO_W'(1);
  assign hb_d      = (state_q == StRun) ? hb_q + HB_W'(1) : '0;
  assign core_in_d = host_gpio_out[CORE_CH*GPIO_W +: GPIO_W];
  assign core_word = core_reset ? '0 : core_gpio_out;

  always_comb begin
    status_word               = '0;
    status_word[1:0]          = state_q;
    status_word[2]            = lock_err_q;
    status_word[3 +: NUM_SW]  = deb_q;
  end

  always_comb begin
    host_in_d = '0;
    for (int unsigned k = 0; k < NUM_GPIO; k++) begin
      unique case (chan_mode[2*k +: 2])
        2'd0:    host_in_d[k*GPIO_W +: GPIO_W] = host_gpio_out[k*GPIO_W +: GPIO_W];
        2'd1:    host_in_d[k*GPIO_W +: GPIO_W] = core_word;
        2'd2:    host_in_d[k*GPIO_W +: GPIO_W] = status_word;
        default: host_in_d[k*GPIO_W +: GPIO_W] = cyc_q;
      endcase
    end
  end

  always_comb begin
    led_d    = '0;
    led_d[0] = hb_q[HB_W-1];
    led_d[1] = ~core_reset;
    led_d[2] = lock_err_q;
    for (int unsigned i = 3; i < NUM_LED; i++) begin
      if (i - 3 < NUM_SW) led_d[i] = deb_q[i-3];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_sync_q <= '0;
      sw_sync_q   <= '0;
      state_q     <= StHold;
      cnt_q       <= '0;
      deb_q       <= '0;
      deb_cnt_q   <= '0;
      lock_err_q  <= 1'b0;
      cyc_q       <= '0;
      hb_q        <= '0;
      core_in_q   <= '0;
      host_in_q   <= '0;
      led_q       <= '0;
    end else begin
      lock_sync_q <= lock_sync_d;
      sw_sync_q   <= sw_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      deb_q       <= deb_d;
      deb_cnt_q   <= deb_cnt_d;
      lock_err_q  <= lock_err_d;
      cyc_q       <= cyc_d;
      hb_q        <= hb_d;
      core_in_q   <= core_in_d;
      host_in_q   <= host_in_d;
      led_q       <= led_d;
    end
  end

  assign host_gpio_in = host_in_q;
  assign core_gpio_in = core_in_q;
  assign led          = led_q;

endmodule

// File: tb/tb_board_supervisor.sv
// Testbench for board_supervisor: directed scenarios followed by random stimulus, every cycle
// compared against a reference model that tracks the sequencer as a "consecutive locked
// samples" streak and the debouncer as a "consecutive differing samples" run length.
module tb_board_supervisor;

  localparam int NUM_GPIO = 4;
  localparam int GPIO_W   = 32;
  localparam int CORE_CH  = 1;
  localparam int RST_HOLD = 16;
  localparam int SYNC     = 2;
  localparam int NUM_SW   = 3;
  localparam int DEB_CYC  = 8;
  localparam int HB_W     = 4;
  localparam int NUM_LED  = 6;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       locked;
  logic [NUM_SW-1:0]          switch_n;
  logic [NUM_GPIO*GPIO_W-1:0] host_gpio_out;
  logic [NUM_GPIO*GPIO_W-1:0] host_gpio_in;
  logic [2*NUM_GPIO-1:0]      chan_mode;
  logic [GPIO_W-1:0]          core_gpio_out;
  logic [GPIO_W-1:0]          core_gpio_in;
  logic                       core_reset;
  logic [NUM_LED-1:0]         led;

  board_supervisor #(
    .NUM_GPIO    (NUM_GPIO),
    .GPIO_W      (GPIO_W),
    .CORE_CH     (CORE_CH),
    .RST_HOLD    (32'(RST_HOLD)),
    .SYNC_STAGES (SYNC),
    .NUM_SW      (NUM_SW),
    .DEB_CYC     (16'(DEB_CYC)),
    .HB_W        (HB_W),
    .NUM_LED     (NUM_LED)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .locked        (locked),
    .switch_n      (switch_n),
    .host_gpio_out (host_gpio_out),
    .host_gpio_in  (host_gpio_in),
    .chan_mode     (chan_mode),
    .core_gpio_out (core_gpio_out),
    .core_gpio_in  (core_gpio_in),
    .core_reset    (core_reset),
    .led           (led)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit                       lk_pipe [SYNC];
  bit [NUM_SW-1:0]          sw_pipe [SYNC];
  int                       m_streak;   // consecutive cycles locked_s has been seen high
  bit                       m_err;
  bit [NUM_SW-1:0]          m_deb;
  int                       m_dlen [NUM_SW];
  bit [GPIO_W-1:0]          m_cyc;
  int                       m_hb;
  bit [GPIO_W-1:0]          m_core_in;
  bit [NUM_GPIO*GPIO_W-1:0] m_host_in;
  bit [NUM_LED-1:0]         m_led;

  function automatic bit m_running();
    return m_streak > RST_HOLD;
  endfunction

  task automatic model_step();
    bit              old_ls;
    bit [NUM_SW-1:0] old_sw;
    bit              old_run;
    int              old_state;
    bit [GPIO_W-1:0] status;
    bit [GPIO_W-1:0] word;
    if (reset) begin
      for (int i = 0; i < SYNC; i++) begin
        lk_pipe[i] = 1'b0;
        sw_pipe[i] = '0;
      end
      for (int s = 0; s < NUM_SW; s++) m_dlen[s] = 0;
      m_streak  = 0;
      m_err     = 1'b0;
      m_deb     = '0;
      m_cyc     = '0;
      m_hb      = 0;
      m_core_in = '0;
      m_host_in = '0;
      m_led     = '0;
      return;
    end
    old_ls    = lk_pipe[SYNC-1];
    old_sw    = sw_pipe[SYNC-1];
    old_run   = m_running();
    old_state = (m_streak == 0) ? 0 : (old_run ? 2 : 1);
    status    = GPIO_W'(old_state) | (GPIO_W'(m_err) << 2) | (GPIO_W'(m_deb) << 3);

    for (int k = 0; k < NUM_GPIO; k++) begin
      case (chan_mode[2*k +: 2])
        2'd0:    word = host_gpio_out[k*GPIO_W +: GPIO_W];
        2'd1:    word = old_run ? core_gpio_out : '0;
        2'd2:    word = status;
        default: word = m_cyc;
      endcase
      m_host_in[k*GPIO_W +: GPIO_W] = word;
    end
    m_core_in = host_gpio_out[CORE_CH*GPIO_W +: GPIO_W];

    m_led    = '0;
    m_led[0] = ((m_hb >> (HB_W - 1)) & 1) != 0;
    m_led[1] = old_run;
    m_led[2] = m_err;
    for (int i = 3; i < NUM_LED; i++) begin
      if (i - 3 < NUM_SW) m_led[i] = m_deb[i-3];
    end

    if (old_run && !old_ls) m_err = 1'b1;
    else if (m_deb[0]) m_err = 1'b0;

    if (!old_ls) m_streak = 0;
    else if (m_streak <= RST_HOLD) m_streak++;

    m_hb  = old_run ? (m_hb + 1) % (1 << HB_W) : 0;
    m_cyc = m_cyc + 1;

    for (int s = 0; s < NUM_SW; s++) begin
      if (old_sw[s] != m_deb[s]) begin
        m_dlen[s]++;
        if (m_dlen[s] == DEB_CYC) begin
          m_deb[s]  = old_sw[s];
          m_dlen[s] = 0;
        end
      end else begin
        m_dlen[s] = 0;
      end
    end

    for (int i = SYNC - 1; i > 0; i--) begin
      lk_pipe[i] = lk_pipe[i-1];
      sw_pipe[i] = sw_pipe[i-1];
    end
    lk_pipe[0] = locked;
    sw_pipe[0] = ~switch_n;
  endtask

  // One clock: advance the model at the edge, compare all outputs 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_eq("core_reset", 256'(core_reset), 256'(!m_running()));
    check_eq("led", 256'(led), 256'(m_led));
    check_eq("core_gpio_in", 256'(core_gpio_in), 256'(m_core_in));
    check_eq("host_gpio_in", 256'(host_gpio_in), 256'(m_host_in));
  endtask

  task automatic wait_run(input string tag);
    int n;
    n = 0;
    while (core_reset && n < 100) begin
      cycle();
      n++;
    end
    check_eq(tag, 256'(core_reset), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int fall;
    int toggles;
    bit prev;

    reset         = 1'b1;
    locked        = 1'b1;
    switch_n      = '1;
    chan_mode     = {2'd3, 2'd2, 2'd1, 2'd0};
    host_gpio_out = '0;
    core_gpio_out = 32'h0000_1234;

    // Reset state
    repeat (3) cycle();
    check_eq("rst_core_reset", 256'(core_reset), 256'(1));
    check_eq("rst_led", 256'(led), 256'(0));
    check_eq("rst_host_in", 256'(host_gpio_in), 256'(0));
    check_eq("rst_core_in", 256'(core_gpio_in), 256'(0));

    // Release with lock held: core_reset falls at edge e0+18
    reset = 1'b0;
    fall  = -1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (fall < 0 && !core_reset) fall = i;
    end
    check_eq("release_latency", 256'(fall), 256'(18));

    // Lock dropped mid-count: full hold restarts, no lock_err
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 40 && m_streak != 9; i++) cycle();
    locked = 1'b0;
    repeat (4) cycle();
    locked = 1'b1;
    fall   = -1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (fall < 0 && !core_reset) fall = i;
    end
    check_eq("relock_latency", 256'(fall), 256'(18));
    check_eq("count_drop_no_err", 256'(led[2]), 256'(0));

    // Lock lost in RUN
    locked = 1'b0;
    repeat (3) cycle();
    check_eq("run_drop_core_reset", 256'(core_reset), 256'(1));
    repeat (2) cycle();
    check_eq("err_led", 256'(led[2]), 256'(1));
    check_eq("err_status_bit", 256'(host_gpio_in[2*GPIO_W+2]), 256'(1));
    switch_n[0] = 1'b0;
    repeat (DEB_CYC + SYNC + 3) cycle();
    check_eq("err_cleared", 256'(led[2]), 256'(0));
    switch_n[0] = 1'b1;

    // Loopback and core-word readback on channel 3
    chan_mode[7:6]      = 2'd0;
    host_gpio_out[127:96] = 32'hA5A5_0001;
    cycle();
    check_eq("loop_ch3", 256'(host_gpio_in[127:96]), 256'(32'hA5A5_0001));
    chan_mode[7:6] = 2'd1;
    cycle();
    check_eq("core_word_in_reset", 256'(host_gpio_in[127:96]), 256'(0));
    locked = 1'b1;
    wait_run("wait_run_ch3");
    cycle();
    check_eq("core_word_in_run", 256'(host_gpio_in[127:96]), 256'(32'h0000_1234));

    // Bouncing switch 1 never gets accepted; a steady press does
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) switch_n[1] = ~switch_n[1];
      cycle();
    end
    check_eq("bounce_rejected", 256'(led[4]), 256'(0));
    switch_n[1] = 1'b0;
    repeat (DEB_CYC + 4) cycle();
    check_eq("press_accepted", 256'(led[4]), 256'(1));
    switch_n[1] = 1'b1;

    // Heartbeat: period 16 cycles in RUN -> 4 toggles in 32 cycles
    prev    = led[0];
    toggles = 0;
    for (int i = 0; i < 32; i++) begin
      cycle();
      if (led[0] != prev) toggles++;
      prev = led[0];
    end
    check_eq("heartbeat_toggles", 256'(toggles), 256'(4));
    locked = 1'b0;
    repeat (5) cycle();
    check_eq("heartbeat_held", 256'(led[0]), 256'(0));
    locked = 1'b1;

    // Random stimulus against the model
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(63) == 0) locked = ~locked;
      for (int s = 0; s < NUM_SW; s++) begin
        if ($urandom_range(15) == 0) switch_n[s] = ~switch_n[s];
      end
      if ($urandom_range(15) == 0) chan_mode = 8'($urandom);
      host_gpio_out = {$urandom, $urandom, $urandom, $urandom};
      core_gpio_out = $urandom;
      reset         = ($urandom_range(499) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
